// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: turns N_CH channel values into spike times inside a gamma cycle.
// Optional TEMPORAL_STEP_EN selects step (level) coding instead of the default pulse coding.
module temporal_encoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int N_CH              = 4,
   parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
   input  logic                   aclk,
   input  logic                   grst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_CH*VAL_W-1:0]  in_vals,
   input  logic                   enable,
   output logic                   set,
   output logic [N_CH-1:0]        spike,
   output logic [VAL_W-1:0]       gamma_cnt,
   output logic                   busy
);

   localparam logic [VAL_W-1:0] T_LAST    = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [VAL_W:0]   GAMMA_EXT = (VAL_W+1)'(GAMMA_CYCLE_WIDTH);
   localparam logic [VAL_W-1:0] NO_SPIKE  = '1;
`ifndef TEMPORAL_STEP_EN
   localparam logic [VAL_W:0]   PW_EXT    = (VAL_W+1)'(PULSE_WIDTH);
`endif

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                  state, state_nxt;
   logic                    shadow_full, shadow_full_nxt;
   logic [N_CH*VAL_W-1:0]   shadow_vals, shadow_nxt;
   logic [N_CH*VAL_W-1:0]   active_vals, active_nxt;
   logic [VAL_W-1:0]        t_nxt;
   logic [VAL_W:0]          t_ext;
   logic                    busy_nxt, set_nxt;
   logic [N_CH-1:0]         spike_nxt;
   logic                    accept, transfer;

   assign accept = in_valid & in_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (grst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      transfer  = 1'b0;
      t_nxt     = '0;
      case (state)
         S_IDLE: begin
            if (enable && shadow_full) begin
               transfer  = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (gamma_cnt == T_LAST) begin
               // Back-to-back start only if a vector is already waiting in the shadow.
               if (enable && shadow_full) transfer  = 1'b1;
               else                       state_nxt = S_IDLE;
            end else begin
               t_nxt = gamma_cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      shadow_full_nxt = shadow_full;
      shadow_nxt      = shadow_vals;
      active_nxt      = active_vals;
      if (transfer) begin
         shadow_full_nxt = 1'b0;
         active_nxt      = shadow_vals;
      end
      if (accept) begin
         shadow_full_nxt = 1'b1;
         shadow_nxt      = in_vals;
      end
   end

   assign busy_nxt = (state_nxt == S_RUN);
   assign set_nxt  = busy_nxt && (t_nxt == '0);
   assign t_ext    = {1'b0, t_nxt};

   // Outputs are computed from next-cycle values so the flops present aligned t and active data.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [VAL_W:0] v_ext;
      assign v_ext = {1'b0, active_nxt[i*VAL_W +: VAL_W]};
`ifdef TEMPORAL_STEP_EN
      assign spike_nxt[i] = busy_nxt && (v_ext < GAMMA_EXT) && (t_ext >= v_ext);
`else
      assign spike_nxt[i] = busy_nxt && (v_ext < GAMMA_EXT) && (t_ext >= v_ext)
                            && (t_ext < v_ext + PW_EXT);
`endif
   end

   // NOTE: shadow and active storage are reset too, so a stale vector can never replay after reset.
   always_ff @(posedge aclk) begin
      if (grst) begin
         shadow_full <= 1'b0;
         in_ready    <= 1'b0;
         shadow_vals <= {N_CH{NO_SPIKE}};
         active_vals <= {N_CH{NO_SPIKE}};
         gamma_cnt   <= '0;
         busy        <= 1'b0;
         set         <= 1'b0;
         spike       <= '0;
      end else begin
         shadow_full <= shadow_full_nxt;
         in_ready    <= ~shadow_full_nxt;
         shadow_vals <= shadow_nxt;
         active_vals <= active_nxt;
         gamma_cnt   <= t_nxt;
         busy        <= busy_nxt;
         set         <= set_nxt;
         spike       <= spike_nxt;
      end
   end

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder: behavioural model plus directed and random stimulus.
module tb_temporal_encoder;

   localparam int G    = 16;
   localparam int PW   = 8;
   localparam int NCH  = 4;
   localparam int VW   = 5;

   logic              aclk = 1'b0;
   logic              grst;
   logic              in_valid;
   logic              in_ready;
   logic [NCH*VW-1:0] in_vals;
   logic              enable;
   logic              set;
   logic [NCH-1:0]    spike;
   logic [VW-1:0]     gamma_cnt;
   logic              busy;

   temporal_encoder #(
      .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .N_CH(NCH), .VAL_W(VW)
   ) dut (
      .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
      .in_vals(in_vals), .enable(enable), .set(set), .spike(spike),
      .gamma_cnt(gamma_cnt), .busy(busy)
   );

   always #5 aclk = ~aclk;

   // Hand-computed per-gamma spike bitmaps (bit t = spike at gamma cycle t).
`ifdef TEMPORAL_STEP_EN
   localparam logic [15:0] EXP_BM [6][4] = '{
      '{16'hFFFF, 16'hFFF8, 16'h8000, 16'h0000},
      '{16'hFFFC, 16'hFF80, 16'hFE00, 16'h0000},
      '{16'hFFE0, 16'hFFE0, 16'hFFE0, 16'hFFE0},
      '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
      '{16'hFF00, 16'hFFFE, 16'hF000, 16'h0000},
      '{16'hFC00, 16'hFFF0, 16'hFFC0, 16'hC000}};
`else
   localparam logic [15:0] EXP_BM [6][4] = '{
      '{16'h00FF, 16'h07F8, 16'h8000, 16'h0000},
      '{16'h03FC, 16'h7F80, 16'hFE00, 16'h0000},
      '{16'h1FE0, 16'h1FE0, 16'h1FE0, 16'h1FE0},
      '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF},
      '{16'hFF00, 16'h01FE, 16'hF000, 16'h0000},
      '{16'hFC00, 16'h0FF0, 16'h3FC0, 16'hC000}};
`endif

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [NCH*VW-1:0] pk(input int a, input int b, input int c, input int d);
      return {VW'(d), VW'(c), VW'(b), VW'(a)};
   endfunction

   // ---------------- behavioural model ----------------
   int  cyc = 0;
   bit  m_busy, m_sf, m_in_ready, m_acc, m_start;
   int  m_t;
   int  m_sh[NCH];
   int  m_act[NCH];

   always @(posedge aclk) begin
      cyc++;
      if (grst) begin
         m_busy = 0; m_t = 0; m_sf = 0; m_in_ready = 0;
         for (int i = 0; i < NCH; i++) begin m_sh[i] = G; m_act[i] = G; end
      end else begin
         m_acc   = in_valid && m_in_ready;
         m_start = enable && m_sf && (!m_busy || m_t == G-1);
         if (m_start) begin
            m_act  = m_sh;
            m_sf   = 0;
            m_busy = 1;
            m_t    = 0;
         end else if (m_busy) begin
            if (m_t == G-1) begin m_busy = 0; m_t = 0; end
            else m_t++;
         end
         if (m_acc) begin
            for (int i = 0; i < NCH; i++) m_sh[i] = int'(in_vals[i*VW +: VW]);
            m_sf = 1;
         end
         m_in_ready = !m_sf;
      end
   end

   function automatic logic [NCH-1:0] exp_spike();
      logic [NCH-1:0] r;
      int v, hi;
      r = '0;
      for (int i = 0; i < NCH; i++) begin
         v  = m_act[i];
`ifdef TEMPORAL_STEP_EN
         hi = G;
`else
         hi = (v + PW < G) ? v + PW : G;
`endif
         r[i] = m_busy && (v < G) && (m_t >= v) && (m_t < hi);
      end
      return r;
   endfunction

   bit cmp_en = 0;
   always @(negedge aclk) begin
      if (cmp_en) begin
         check("in_ready",  in_ready,  m_in_ready);
         check("busy",      busy,      m_busy);
         check("set",       set,       m_busy && m_t == 0);
         check("gamma_cnt", gamma_cnt, m_busy ? m_t : 0);
         check("spike",     spike,     exp_spike());
      end
   end

   // ---------------- gamma recorder ----------------
   int          g_cnt = 0;
   int          g_set_cyc[64];
   int          g_busy[64];
   logic [15:0] g_bm[64][NCH];

   always @(negedge aclk) begin
      if (set === 1'b1 && g_cnt < 64) begin
         g_set_cyc[g_cnt] = cyc;
         g_busy[g_cnt]    = 0;
         for (int i = 0; i < NCH; i++) g_bm[g_cnt][i] = '0;
         g_cnt++;
      end
      if (busy === 1'b1 && g_cnt > 0) begin
         g_busy[g_cnt-1]++;
         for (int i = 0; i < NCH; i++) g_bm[g_cnt-1][i][gamma_cnt[3:0]] = spike[i];
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_t(input int tv);
      int n = 0;
      while (!(busy === 1'b1 && gamma_cnt == VW'(tv)) && n < 100) begin tick(); n++; end
      check("wait_gamma_t", n < 100, 1);
   endtask

   task automatic send(input logic [NCH*VW-1:0] v, output int acc_cyc);
      int n = 0;
      in_vals  = v;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
      check("send_ready", n < 100, 1);
      tick();
      acc_cyc  = cyc - 1;
      in_valid = 1'b0;
      in_vals  = NCH*VW'($urandom);
   endtask

   task automatic check_gamma(input string name, input int g, input int row);
      for (int i = 0; i < NCH; i++) check(name, g_bm[g][i], EXP_BM[row][i]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, acc0, acc_bp[3], nspk;
      logic [NCH*VW-1:0] bp_vec[3];

      grst = 1'b1; in_valid = 1'b0; enable = 1'b0; in_vals = '0;
      tick();
      cmp_en = 1;
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      tick(); tick();
      grst = 1'b0;
      tick();
      check("rel_in_ready", in_ready, 1);

      // Single vector
      enable = 1'b1;
      base = g_cnt;
      send(pk(0, 3, 15, 16), acc0);
      wait_t(15);
      tick();
      check("single_idle", busy, 0);
      check("single_count", g_cnt, base + 1);
      check("single_latency", g_set_cyc[base] - acc0, 2);
      check("single_busy_len", g_busy[base], 16);
      check_gamma("single_bm", base, 0);

      // Back-to-back: second vector accepted at t=4
      base = g_cnt;
      send(pk(2, 7, 9, 20), acc0);
      wait_t(4);
      check("b2b_ready_t4", in_ready, 1);
      in_vals = pk(5, 5, 5, 5); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("b2b_ready_t5", in_ready, 0);
      wait_t(15);
      check("b2b_ready_t15", in_ready, 0);
      tick();
      check("b2b_set", set, 1);
      check("b2b_ready_t0", in_ready, 1);
      wait_t(15);
      tick();
      check("b2b_idle", busy, 0);
      check("b2b_gap", g_set_cyc[base+1] - g_set_cyc[base], 16);
      check_gamma("b2b_first_bm", base, 1);
      check_gamma("b2b_second_bm", base + 1, 2);

      // Backpressure: three vectors offered continuously
      base = g_cnt;
      bp_vec[0] = pk(0, 0, 0, 0);
      bp_vec[1] = pk(8, 1, 12, 31);
      bp_vec[2] = pk(10, 4, 6, 14);
      in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         int n = 0;
         in_vals = bp_vec[j];
         while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
         check("bp_ready", n < 100, 1);
         tick();
         acc_bp[j] = cyc - 1;
      end
      in_valid = 1'b0;
      wait_t(15); tick();
      wait_t(15); tick();
      check("bp_idle", busy, 0);
      check("bp_count", g_cnt, base + 3);
      check("bp_lat0", g_set_cyc[base] - acc_bp[0], 2);
      check("bp_acc1", acc_bp[1], g_set_cyc[base]);
      check("bp_acc2", acc_bp[2], g_set_cyc[base+1]);
      check("bp_gap", g_set_cyc[base+2] - g_set_cyc[base+1], 16);
      for (int j = 0; j < 3; j++) check_gamma("bp_bm", base + j, 3 + j);

`ifdef TEMPORAL_STEP_EN
      // Step mode: back-to-back v=0 keeps spike high across both gammas
      base = g_cnt;
      send(pk(0, 0, 0, 0), acc0);
      send(pk(0, 0, 0, 0), acc0);
      wait_t(15); tick();
      wait_t(15); tick();
      check("step_gap", g_set_cyc[base+1] - g_set_cyc[base], 16);
      check("step_bm0", g_bm[base][0], 16'hFFFF);
      check("step_bm1", g_bm[base+1][0], 16'hFFFF);
`endif

      // Enable drop at t=5 with the shadow full
      send(pk(1, 1, 1, 1), acc0);
      send(pk(2, 2, 2, 2), acc0);
      wait_t(5);
      enable = 1'b0;
      wait_t(15);
      tick();
      check("en_idle", busy, 0);
      check("en_ready_low", in_ready, 0);
      tick(); tick(); tick();
      check("en_hold_idle", busy, 0);
      check("en_hold_set", set, 0);
      enable = 1'b1;
      tick();
      check("en_restart_set", set, 1);
      check("en_restart_t", gamma_cnt, 0);
      check("en_restart_ready", in_ready, 1);
      wait_t(15);
      tick();

      // Reset in the middle of a gamma at t=6
      send(pk(0, 0, 0, 0), acc0);
      wait_t(6);
      grst = 1'b1;
      tick();
      check("mrst_busy", busy, 0);
      check("mrst_spike", spike, 0);
      check("mrst_set", set, 0);
      check("mrst_gcnt", gamma_cnt, 0);
      check("mrst_ready", in_ready, 0);
      tick(); tick();
      check("mrst_ready_hold", in_ready, 0);
      grst = 1'b0;
      tick();
      check("mrst_ready_rel", in_ready, 1);
      nspk = 0;
      for (int k = 0; k < 20; k++) begin
         if (spike !== '0 || busy !== 1'b0) nspk++;
         tick();
      end
      check("mrst_quiet", nspk, 0);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         enable   = ($urandom_range(0, 9) < 8);
         in_vals  = pk($urandom_range(0, 24), $urandom_range(0, 24),
                       $urandom_range(0, 24), $urandom_range(0, 24));
         grst     = ($urandom_range(0, 199) == 0);
         tick();
      end
      grst = 1'b0; in_valid = 1'b0; enable = 1'b0;
      for (int k = 0; k < 40; k++) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
